// File: rtl/apb_regfile_slave.sv
// APB3 slave front-end for the 8x8-bit register file: one setup latch, programmable wait states.
// Optional APB_PSLVERR_EN flags misaligned / out-of-range addresses with pslverr.
module apb_regfile_slave #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [7:0]        pwdata,
  output logic [7:0]        prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [2:0]        reg_write_addr,
  output logic [7:0]        reg_write_data,
  output logic              reg_write_en,
  output logic [2:0]        reg_read_addr,
  input  logic [7:0]        reg_read_data
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  state_t      state;
  logic [3:0]  cnt;
  logic [2:0]  idx;
  logic [7:0]  wdata_q;
  logic        write_q;
  logic        err_q;
  logic        addr_err;
  logic        done;

`ifdef APB_PSLVERR_EN
  assign addr_err = (paddr[1:0] != 2'b00) || ((paddr >> 5) != '0);
`else
  logic unused_addr_bits;
  assign addr_err         = 1'b0;
  assign unused_addr_bits = ^{paddr[ADDR_W-1:5], paddr[1:0]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            idx     <= paddr[4:2];
            write_q <= pwrite;
            wdata_q <= pwdata;
            err_q   <= addr_err;
            cnt     <= WS_INIT;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          // Dropping psel before completion aborts the transfer with no side effects.
          if (!psel)
            state <= IDLE;
          else if (cnt != '0)
            cnt <= cnt - 4'd1;
          else if (penable)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    done           = (state == ACCESS) && (cnt == '0) && psel && penable;
    pready         = done;
    pslverr        = done && err_q;
    reg_write_en   = done && write_q && !err_q;
    prdata         = (done && !write_q && !err_q) ? reg_read_data : '0;
    reg_write_addr = idx;
    reg_write_data = wdata_q;
    reg_read_addr  = idx;
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Self-checking bench for apb_regfile_slave: three instances (WAIT_STATES 1, 0, 3), each with a bench regfile.
// Honors APB_PSLVERR_EN the same way the design does.
module tb_apb_regfile_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rf_init = 1'b1;
  logic       psel_a [3];
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [7:0] paddr = '0;
  logic [7:0] pwdata = '0;

  logic [7:0] prdata_a [3];
  logic       pready_a [3];
  logic       pslverr_a [3];
  logic [2:0] wa_a [3];
  logic [7:0] wd_a [3];
  logic       we_a [3];
  logic [2:0] ra_a [3];
  logic [7:0] rd_a [3];

  logic [7:0] rf [3][8];
  logic [7:0] exp_mem [3][8];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         d;
    bit         wr;
    logic [2:0] idx;
    logic [7:0] wd;
    logic [7:0] rd;
    bit         err;
    int         lat;
  } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WS = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    apb_regfile_slave #(.WAIT_STATES(WS), .ADDR_W(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .psel           (psel_a[g]),
      .penable        (penable),
      .pwrite         (pwrite),
      .paddr          (paddr),
      .pwdata         (pwdata),
      .prdata         (prdata_a[g]),
      .pready         (pready_a[g]),
      .pslverr        (pslverr_a[g]),
      .reg_write_addr (wa_a[g]),
      .reg_write_data (wd_a[g]),
      .reg_write_en   (we_a[g]),
      .reg_read_addr  (ra_a[g]),
      .reg_read_data  (rd_a[g])
    );
  end

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rf_init) begin
        for (int i = 0; i < 8; i++) rf[g][i] <= 8'(g * 16 + i);
      end else if (we_a[g]) begin
        rf[g][wa_a[g]] <= wd_a[g];
      end
    end
  end

  always_comb begin
    for (int g = 0; g < 3; g++) rd_a[g] = rf[g][ra_a[g]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_is_err(input logic [7:0] a);
`ifdef APB_PSLVERR_EN
    return (a[1:0] != 2'b00) || (a[7:5] != 3'b000);
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle();
    @(negedge clk);
    for (int g = 0; g < 3; g++) psel_a[g] = 1'b0;
    penable = 1'b0;
  endtask

  // One full APB transfer on instance d; the expected result is queued at setup time.
  task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [7:0] data, input int ws);
    exp_t e;
    exp_t got;
    int   cyc;
    e.d   = d;
    e.wr  = wr;
    e.idx = a[4:2];
    e.wd  = data;
    e.err = addr_is_err(a);
    e.rd  = (wr || e.err) ? 8'h00 : exp_mem[d][a[4:2]];
    e.lat = 2 + ws;
    if (wr && !e.err) exp_mem[d][a[4:2]] = data;
    sb.push_back(e);

    @(negedge clk);
    for (int g = 0; g < 3; g++) psel_a[g] = (g == d);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = data;
    @(negedge clk);
    penable = 1'b1;
    paddr   = ~a;
    pwdata  = ~data;
    #1;
    cyc = 2;
    while (!pready_a[d] && cyc < 20) begin
      check("wait_no_write", we_a[d], 0);
      check("wait_prdata_zero", prdata_a[d], 0);
      @(negedge clk);
      #1;
      cyc++;
    end
    if (!pready_a[d]) begin
      check("pready_timeout", pready_a[d], 1);
    end else if (sb.size() == 0) begin
      check("unexpected_pready", sb.size(), 1);
    end else begin
      got = sb.pop_front();
      check("latency", cyc, got.lat);
      check("pslverr", pslverr_a[d], got.err);
      check("write_en", we_a[d], got.wr && !got.err);
      check("read_addr", ra_a[d], got.idx);
      if (got.wr) begin
        check("write_addr", wa_a[d], got.idx);
        check("write_data", wd_a[d], got.wd);
      end
      check("prdata", prdata_a[d], got.rd);
    end
  endtask

  task automatic check_rf(input string tag, input int d, input int i);
    check(tag, rf[d][i], exp_mem[d][i]);
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      psel_a[g] = 1'b0;
      for (int i = 0; i < 8; i++) exp_mem[g][i] = 8'(g * 16 + i);
    end

    // Reset held for 3 cycles
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("rst_prdata", prdata_a[g], 0);
      check("rst_pready", pready_a[g], 0);
      check("rst_pslverr", pslverr_a[g], 0);
      check("rst_we", we_a[g], 0);
      check("rst_wa", wa_a[g], 0);
      check("rst_wd", wd_a[g], 0);
      check("rst_ra", ra_a[g], 0);
    end
    rst = 1'b0;
    rf_init = 1'b0;
    repeat (5) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) check("idle_no_write", we_a[g], 0);
    end

    // Write then immediate read-back, WAIT_STATES=1
    xfer(0, 1'b1, 8'h0C, 8'hA5, 1);
    xfer(0, 1'b0, 8'h0C, 8'h00, 1);
    idle();
    check_rf("rf0_reg3", 0, 3);
    check("rf0_reg3_val", rf[0][3], 8'hA5);

    // WAIT_STATES=0: write/read in 2 cycles each, back to back
    xfer(1, 1'b1, 8'h1C, 8'h3C, 0);
    xfer(1, 1'b0, 8'h1C, 8'h00, 0);
    xfer(1, 1'b0, 8'h04, 8'h00, 0);
    idle();
    check_rf("rf1_reg7", 1, 7);

    // Abort: psel dropped in the first ACCESS cycle
    @(negedge clk);
    psel_a[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 8'h77;
    @(negedge clk);
    psel_a[0] = 1'b0;
    #1;
    check("abort_pready", pready_a[0], 0);
    check("abort_we", we_a[0], 0);
    repeat (4) begin
      @(negedge clk);
      check("abort_no_pready", pready_a[0], 0);
      check("abort_no_we", we_a[0], 0);
    end
    check_rf("abort_reg4", 0, 4);
    xfer(0, 1'b1, 8'h14, 8'h5E, 1);
    xfer(0, 1'b0, 8'h10, 8'h00, 1);
    idle();
    check_rf("post_abort_reg5", 0, 5);

    // Async reset between edges during a WAIT_STATES=3 write
    @(negedge clk);
    psel_a[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 8'h5A;
    @(negedge clk);
    penable = 1'b1;
    #1;
    check("ws3_wait", pready_a[2], 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pready", pready_a[2], 0);
    check("arst_we", we_a[2], 0);
    check("arst_wa", wa_a[2], 0);
    check("arst_wd", wd_a[2], 0);
    check("arst_ra", ra_a[2], 0);
    check("arst_prdata", prdata_a[2], 0);
    psel_a[2] = 1'b0; penable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_rf("arst_reg2_kept", 2, 2);
    xfer(2, 1'b1, 8'h08, 8'hC3, 3);
    xfer(2, 1'b0, 8'h08, 8'h00, 3);
    idle();
    check_rf("ws3_reg2", 2, 2);

    // Address error (or plain write to reg 0 without APB_PSLVERR_EN)
    xfer(0, 1'b1, 8'h21, 8'hFF, 1);
    xfer(0, 1'b0, 8'h00, 8'h00, 1);
    xfer(0, 1'b0, 8'hE4, 8'h00, 1);
    idle();
    @(negedge clk);
    check_rf("err_reg0", 0, 0);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
